// File: rtl/ram_access_ctrl.sv
// CPU-side initiator for the 4004-style 4096x4 data RAM.
// Holds the DCL bank and SRC address and sequences RAM strobes per command.
module ram_access_ctrl #(
    parameter int BANK_W = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [2:0]        reqOp,
    input  logic [7:0]        reqData,
    input  logic [1:0]        reqIdx,
    output logic              rspValid,
    output logic [3:0]        rspData,
    output logic              rspErr,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramWe,
    output logic              ramRe,
    output logic [3:0]        ramWData,
    input  logic [3:0]        ramRData
);

    localparam logic [2:0] OP_SRC = 3'd0;
    localparam logic [2:0] OP_DCL = 3'd1;
    localparam logic [2:0] OP_WRM = 3'd2;
    localparam logic [2:0] OP_RDM = 3'd3;
    localparam logic [2:0] OP_WRS = 3'd4;
    localparam logic [2:0] OP_RDS = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RSP
    } state_t;

    state_t              r_state;
    logic [7:0]          r_src;
    logic [BANK_W-1:0]   r_bank;
    logic                r_err;
    logic [3:0]          r_rspData;
    logic                r_rspValid;
    logic                r_ramWe;
    logic                r_ramRe;
    logic [ADDR_W-1:0]   r_ramAddr;
    logic [3:0]          r_ramWData;

    logic [ADDR_W-1:0]   w_addrMain;
    logic [ADDR_W-1:0]   w_addrStat;
    logic [ADDR_W-1:0]   w_addr;

    // Status characters live in the upper half, four per register.
    assign w_addrMain = {1'b0, r_bank, r_src};
    assign w_addrStat = {1'b1, r_bank, r_src[7:4], 2'b00, reqIdx};
    assign w_addr     = reqOp[2] ? w_addrStat : w_addrMain;

    assign reqReady = (r_state == S_IDLE) && !rst;
    assign rspValid = r_rspValid;
    assign rspData  = r_rspData;
    assign rspErr   = r_err;
    assign ramAddr  = r_ramAddr;
    assign ramWe    = r_ramWe;
    assign ramRe    = r_ramRe;
    assign ramWData = r_ramWData;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_bank     <= '0;
            r_err      <= 1'b0;
            r_rspData  <= '0;
            r_rspValid <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramRe    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWData <= '0;
        end else begin
            r_rspValid <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramRe    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (reqValid) begin
                        case (reqOp)
                            OP_SRC: begin
                                r_src      <= reqData;
                                r_err      <= 1'b0;
                                r_rspData  <= '0;
                                r_rspValid <= 1'b1;
                                r_state    <= S_RSP;
                            end
                            OP_DCL: begin
                                r_bank     <= reqData[BANK_W-1:0];
                                r_err      <= 1'b0;
                                r_rspData  <= '0;
                                r_rspValid <= 1'b1;
                                r_state    <= S_RSP;
                            end
                            OP_WRM, OP_WRS: begin
                                // Write completes in the strobe cycle itself.
                                r_ramWe    <= 1'b1;
                                r_ramAddr  <= w_addr;
                                r_ramWData <= reqData[3:0];
                                r_err      <= 1'b0;
                                r_rspData  <= '0;
                                r_rspValid <= 1'b1;
                                r_state    <= S_WR;
                            end
                            OP_RDM, OP_RDS: begin
                                r_ramRe    <= 1'b1;
                                r_ramAddr  <= w_addr;
                                r_err      <= 1'b0;
                                r_state    <= S_RD_ISSUE;
                            end
                            default: begin
                                r_err      <= 1'b1;
                                r_rspData  <= '0;
                                r_rspValid <= 1'b1;
                                r_state    <= S_RSP;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    r_state <= S_IDLE;
                end
                S_RD_ISSUE: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_rspData  <= ramRData;
                    r_rspValid <= 1'b1;
                    r_state    <= S_RSP;
                end
                S_RSP: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
